seg_scan_driver: RTL

- Upstream frame source for the 16-bit serial shift-register output stage; replaces ad-hoc digit multiplexing logic in top-level designs.
- Holds a multi-digit hex value and scans one digit per refresh tick.
- Per digit: decodes the nibble to 7-segment form, builds {one-hot digit select, segments}, and offers the word over a valid/ready handshake.
- Value updates are double-buffered and take effect only at frame boundaries, so a display never shows a mix of old and new digits.

---
 rtl/seg_scan_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multi-digit hex scanner: one digit per refresh tick, decoded to 7-segment and
// offered as {one-hot select, segments} over valid/ready. Value updates land only at frame start.
module seg_scan_driver #(
    parameter int NUM_DIGITS    = 3,
    parameter int TICK_DIV_BITS = 6,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    CLK,
    input  logic                    i_reset_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_load,
    output logic [15:0]             o_word,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2:0]              o_digit_idx,
    output logic                    o_frame_done,
    output logic                    o_missed_tick
);
    localparam int VW = 4 * NUM_DIGITS;

    typedef enum logic {S_WAIT, S_OFFER} state_t;

    state_t                   state_reg;
    logic [TICK_DIV_BITS-1:0] prescaler_reg;
    logic [VW-1:0]            pending_reg;
    logic [VW-1:0]            active_reg;
    logic                     pend_flag_reg;
    logic [2:0]               idx_reg;
    logic [15:0]              word_reg;
    logic                     valid_reg;
    logic                     frame_done_reg;
    logic                     missed_tick_reg;

    logic          tick;
    logic          transfer;
    logic          handshake;
    logic          last_digit;
    logic          blank;
    logic [VW-1:0] value_sel;
    logic [3:0]    nib [8];
    logic [7:0]    upper_zero;
    logic [7:0]    seg_raw;
    logic [15:0]   word_next;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    return 8'h3F;
            4'h1:    return 8'h06;
            4'h2:    return 8'h5B;
            4'h3:    return 8'h4F;
            4'h4:    return 8'h66;
            4'h5:    return 8'h6D;
            4'h6:    return 8'h7D;
            4'h7:    return 8'h07;
            4'h8:    return 8'h7F;
            4'h9:    return 8'h6F;
            4'hA:    return 8'h77;
            4'hB:    return 8'h7C;
            4'hC:    return 8'h39;
            4'hD:    return 8'h5E;
            4'hE:    return 8'h79;
            default: return 8'h71;
        endcase
    endfunction

    assign tick       = &prescaler_reg;
    assign handshake  = valid_reg & i_ready;
    assign last_digit = (idx_reg == 3'(NUM_DIGITS - 1));
    assign transfer   = (state_reg == S_WAIT) && tick && (idx_reg == 3'd0) && pend_flag_reg;
    // The first digit of a new frame already shows the freshly transferred value.
    assign value_sel  = transfer ? pending_reg : active_reg;

    // Per-digit nibble and "this and every higher nibble is zero" flags, padded to 8 digits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_used
                assign nib[gi]        = value_sel[4*gi +: 4];
                assign upper_zero[gi] = ~|value_sel[VW-1:4*gi];
            end else begin : g_unused
                assign nib[gi]        = 4'h0;
                assign upper_zero[gi] = 1'b1;
            end
        end
    endgenerate

    assign seg_raw   = hex_to_seg(nib[idx_reg]);
    assign blank     = (BLANK_LEADING != 0) && (idx_reg != 3'd0) && upper_zero[idx_reg];
    assign word_next = {8'b1 << idx_reg, blank ? 8'h00 : seg_raw};

    always_ff @(posedge CLK) begin
        if (!i_reset_n) begin
            state_reg       <= S_WAIT;
            prescaler_reg   <= '0;
            pending_reg     <= '0;
            active_reg      <= '0;
            pend_flag_reg   <= 1'b0;
            idx_reg         <= 3'd0;
            word_reg        <= 16'h0000;
            valid_reg       <= 1'b0;
            frame_done_reg  <= 1'b0;
            missed_tick_reg <= 1'b0;
        end else begin
            prescaler_reg   <= prescaler_reg + 1'b1;
            frame_done_reg  <= 1'b0;
            missed_tick_reg <= 1'b0;

            if (i_load) begin
                pending_reg   <= i_value;
                pend_flag_reg <= 1'b1;
            end

            case (state_reg)
                S_WAIT: begin
                    if (tick) begin
                        word_reg  <= word_next;
                        valid_reg <= 1'b1;
                        state_reg <= S_OFFER;
                        if (transfer) begin
                            active_reg <= pending_reg;
                            // A load arriving on the transfer cycle stays pending.
                            if (!i_load) begin
                                pend_flag_reg <= 1'b0;
                            end
                        end
                    end
                end
                S_OFFER: begin
                    if (tick) begin
                        missed_tick_reg <= 1'b1;
                    end
                    if (handshake) begin
                        valid_reg <= 1'b0;
                        state_reg <= S_WAIT;
                        if (last_digit) begin
                            idx_reg        <= 3'd0;
                            frame_done_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                default: state_reg <= S_WAIT;
            endcase
        end
    end

    assign o_word        = word_reg;
    assign o_valid       = valid_reg;
    assign o_digit_idx   = idx_reg;
    assign o_frame_done  = frame_done_reg;
    assign o_missed_tick = missed_tick_reg;
endmodule
